// File: rtl/bp_train_scheduler.sv
// bp_train_scheduler: shares one perceptron datapath between fetch predictions and in-order commit training.
// Ports: clk/rst (async, active-high); pred_* fetch request/grant/response; resolve_* commit outcome and
// resolve_err; flush drops in-flight entries; occupancy; bp_* drive and observe the predictor.
module bp_train_scheduler #(
  parameter int DEPTH = 8,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pred_req,
  input  logic [31:0]      pred_pc,
  output logic             pred_gnt,
  output logic [TAG_W-1:0] pred_tag,
  output logic             pred_resp_valid,
  output logic             pred_resp_taken,
  output logic [TAG_W-1:0] pred_resp_tag,
  input  logic             resolve_valid,
  input  logic [TAG_W-1:0] resolve_tag,
  input  logic             resolve_taken,
  output logic             resolve_err,
  input  logic             flush,
  output logic [TAG_W:0]   occupancy,
  output logic [31:0]      bp_pc,
  output logic             bp_predict_en,
  input  logic             bp_prediction,
  input  logic             bp_prediction_valid,
  output logic             bp_train_en,
  output logic [31:0]      bp_train_pc,
  output logic             bp_actual_taken,
  output logic             bp_hist_upd_en,
  output logic             bp_branch_taken
);
  typedef enum logic [1:0] {IDLE, PRED, TRAIN_RD} state_t;
  state_t state_q, state_d;
  logic [TAG_W:0] head_q, head_d, tail_q, tail_d;
  logic [31:0] pc_q [DEPTH];
  logic [31:0] pc_d [DEPTH];
  logic [DEPTH-1:0] ptk_q, ptk_d, res_q, res_d, act_q, act_d;
  logic [31:0] tr_pc_q, tr_pc_d;
  logic tr_act_q, tr_act_d, skip_q, skip_d, err_q, err_d;
  logic [TAG_W-1:0] ptag_q, ptag_d, hidx, tidx, rel;
  logic full, rvalid, rok, pop, gnt, pdone, tdone;
  always_comb begin
    hidx = head_q[TAG_W-1:0];
    tidx = tail_q[TAG_W-1:0];
    occupancy = tail_q - head_q;
    full = (hidx == tidx) && (head_q[TAG_W] != tail_q[TAG_W]);
    rel = resolve_tag - hidx;
    rvalid = {1'b0, rel} < occupancy;
    rok = rvalid && !res_q[resolve_tag];
    pop = (state_q == IDLE) && (occupancy != '0) && res_q[hidx];
    gnt = (state_q == IDLE) && !pop && pred_req && !full;
    pdone = (state_q == PRED) && bp_prediction_valid;
    tdone = (state_q == TRAIN_RD) && bp_prediction_valid;
    pred_gnt = gnt;
    pred_tag = gnt ? tidx : '0;
    bp_predict_en = pop || gnt;
    bp_pc = pop ? pc_q[hidx] : (gnt ? pred_pc : 32'd0);
    pred_resp_valid = pdone;
    pred_resp_taken = pdone && bp_prediction;
    pred_resp_tag = pdone ? ptag_q : '0;
    bp_train_en = tdone;
    bp_train_pc = tdone ? tr_pc_q : 32'd0;
    bp_actual_taken = tdone && tr_act_q;
    bp_hist_upd_en = tdone;
    bp_branch_taken = tdone && tr_act_q;
    resolve_err = err_q;
    state_d = pop ? TRAIN_RD : (gnt ? PRED : ((pdone || tdone) ? IDLE : state_q));
    head_d = head_q + (TAG_W+1)'(pop);
    // flush wins over a same-cycle grant, so the new tail is the post-pop head
    tail_d = flush ? head_d : tail_q + (TAG_W+1)'(gnt);
    pc_d = pc_q;
    ptk_d = ptk_q;
    res_d = res_q;
    act_d = act_q;
    if (gnt) begin
      pc_d[tidx] = pred_pc;
      res_d[tidx] = 1'b0;
    end
    if (pdone && !skip_q && !flush) ptk_d[ptag_q] = bp_prediction;
    if (resolve_valid && rok) begin
      res_d[resolve_tag] = 1'b1;
      act_d[resolve_tag] = resolve_taken;
    end
    err_d = resolve_valid && !rok;
    tr_pc_d = pop ? pc_q[hidx] : tr_pc_q;
    tr_act_d = pop ? act_q[hidx] : tr_act_q;
    ptag_d = gnt ? tidx : ptag_q;
    // a flush seen at grant or during the wait invalidates the pending entry
    skip_d = gnt ? flush : (skip_q || flush);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      head_q <= '0;
      tail_q <= '0;
      for (int i = 0; i < DEPTH; i++) pc_q[i] <= '0;
      ptk_q <= '0;
      res_q <= '0;
      act_q <= '0;
      tr_pc_q <= '0;
      tr_act_q <= 1'b0;
      ptag_q <= '0;
      skip_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q <= head_d;
      tail_q <= tail_d;
      pc_q <= pc_d;
      ptk_q <= ptk_d;
      res_q <= res_d;
      act_q <= act_d;
      tr_pc_q <= tr_pc_d;
      tr_act_q <= tr_act_d;
      ptag_q <= ptag_d;
      skip_q <= skip_d;
      err_q <= err_d;
    end
  end
endmodule

// File: doc/bp_train_scheduler.md
# bp_train_scheduler

Sequencing controller that sits in front of `perceptron_predictor` and shares its single prediction datapath between fetch-side prediction requests and commit-side training. It keeps an in-order table of in-flight predicted branches. When the oldest branch resolves, it replays that branch's PC through the dot-product path so the predictor's live confidence refers to the branch being trained. It then fires one training and history-update pulse. Fetch is stalled while a training replay is in progress.

## Interface
Parameters:
- `DEPTH`, 8, number of in-flight branch entries; power of two, at least 2
- `TAG_W`, `$clog2(DEPTH)`, tag width

Ports:
- `clk`, in, 1, clock
- `rst`, in, 1, reset; asynchronous, active-high
- `pred_req`, in, 1, fetch requests a prediction
- `pred_pc`, in, 32, PC of the requesting branch
- `pred_gnt`, out, 1, request accepted this cycle
- `pred_tag`, out, TAG_W, tag allocated to the accepted request; valid with `pred_gnt`
- `pred_resp_valid`, out, 1, 1-cycle pulse: prediction result is available
- `pred_resp_taken`, out, 1, predicted direction
- `pred_resp_tag`, out, TAG_W, tag of the response
- `resolve_valid`, in, 1, a branch has resolved
- `resolve_tag`, in, TAG_W, tag of the resolved branch
- `resolve_taken`, in, 1, actual outcome
- `resolve_err`, out, 1, 1-cycle pulse: resolve targeted a free or already-resolved entry
- `flush`, in, 1, drop all in-flight entries
- `occupancy`, out, TAG_W+1, number of valid entries
- `bp_pc`, out, 32, drives predictor `pc`
- `bp_predict_en`, out, 1, drives predictor `predict_en`
- `bp_prediction`, in, 1, from predictor `prediction`
- `bp_prediction_valid`, in, 1, from predictor `prediction_valid`
- `bp_train_en`, out, 1, drives predictor `train_en`
- `bp_train_pc`, out, 32, drives predictor `train_pc`
- `bp_actual_taken`, out, 1, drives predictor `actual_taken`
- `bp_hist_upd_en`, out, 1, drives predictor `history_update_en`
- `bp_branch_taken`, out, 1, drives predictor `branch_taken`

## Operation
- **Entry table:** circular buffer of DEPTH entries. Each entry holds `pc`, `pred_taken`, `resolved` and `actual`. Head and tail pointers carry TAG_W+1 bits (an extra wrap bit). The table is empty when the pointers are equal and full when the low bits match and the wrap bits differ. The tag is the low TAG_W bits of tail at allocation.
- **FSM states:**
  - **IDLE:**
    - If head is valid and resolved, pop head into `tr_pc`/`tr_act` registers, assert `bp_predict_en` with `bp_pc`=head `pc`, and go to TRAIN_RD. Training has priority over fetch.
    - Otherwise, if `pred_req` is high and the table is not full, assert `pred_gnt`, `bp_predict_en` and `bp_pc`=`pred_pc`, allocate at tail, and go to PRED.
  - **PRED:** expects `bp_prediction_valid`. Write `bp_prediction` into the entry's `pred_taken` and pulse `pred_resp_valid` with the taken bit and tag. Go to IDLE.
  - **TRAIN_RD:** expects `bp_prediction_valid`. Assert `bp_train_en`, `bp_train_pc`=`tr_pc`, `bp_actual_taken`=`tr_act`, `bp_hist_upd_en`=1 and `bp_branch_taken`=`tr_act`. Go to IDLE.
  - If `bp_prediction_valid` is low in PRED or TRAIN_RD, remain in the state with no outputs. This is a wait, not an error.
- `pred_gnt` is asserted only in IDLE. `bp_pc` drives 0 when `bp_predict_en` is low.
- **Resolve:** accepted in any state. The entry is valid when (tag − head) mod DEPTH < occupancy.
  - For a valid entry that is not yet resolved, set `resolved`=1 and `actual`=`resolve_taken`.
  - Otherwise, pulse `resolve_err` the next cycle and leave the table unchanged.
- **Flush:** sets tail to head (occupancy 0) at the next edge.
  - An in-progress TRAIN_RD completes normally, because its data is already popped.
  - An in-progress PRED still emits its response, but skips the table write.
  - A grant and a flush in the same cycle: flush wins, and the allocation is discarded.
- **Reset:** clears everything. State=IDLE, pointers=0, all outputs 0, all `resolved` bits 0.

## Timing
- Predictor latency: result is valid 1 cycle after `bp_predict_en`.
- Prediction: grant at T, response at T+1 (minimum). Back-to-back requests are granted at T, T+2, T+4 and so on.
- Training: pop at T, `bp_train_en`/`bp_hist_upd_en` pulse at T+1. A fetch grant is possible at T+2 at the earliest.
- A resolve at T is visible to the IDLE pop check at T+1. A resolve of the head in the same cycle as an IDLE decision does not pop that cycle.
- A resolve at T+1 of a tag granted at T is legal. Its `resolved`/`actual` fields and the PRED write of `pred_taken` land in the same cycle without conflict.
- `occupancy` updates on the edge after a grant or pop. A simultaneous grant and pop cannot occur, because the FSM is exclusive.
- Asynchronous `rst` mid-PRED or mid-TRAIN_RD aborts immediately. No pulses are emitted after release.

## Test plan
- **Single round trip:** reset, `pred_req` with pc=0x1000 -> `pred_gnt`, tag 0 at T. `pred_resp_valid` at T+1. Resolve tag 0 taken=1 -> `bp_train_en` with `bp_train_pc`=0x1000, actual 1, and `bp_hist_upd_en`=1, exactly 2 cycles after the resolve.
- **Full and wrap:** grant 8 requests -> tags 0..7, occupancy 8, and `pred_gnt` held 0. Resolve tag 0 -> pop, then the next grant gets tag 0 again.
- **Out-of-order resolve:** resolve tags 2, 1, then 0 -> training pulses in order 0, 1, 2, each separated by at least 2 cycles.
- **Priority:** `pred_req` held high while head is resolved -> TRAIN_RD is taken first, and the grant comes 2 cycles later.
- **Bad resolve:** resolve a free tag, or resolve tag 0 twice -> `resolve_err` pulse and occupancy unchanged.
- **Flush and reset:** flush during PRED -> response pulse still occurs, occupancy 0, no training. Asserting `rst` during TRAIN_RD -> all outputs 0 and no `bp_train_en`.
